// File: rtl/ifu_pc_seq.sv
`default_nettype none
// ============================================================================
// Module      : ifu_pc_seq
// Description : IFU fetch PC sequencer; issues fetches, drops flushed responses
//               and supplies PCR/EPC to the exception unit.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_pc_seq #(
    parameter int                PC_W    = 32,
    parameter logic [PC_W-1:0]   RST_VEC = '0,
    parameter int                OUTS    = 2,
    parameter int                CNT_W   = $clog2(OUTS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pc_i_excp_req,
    input  logic                 pc_i_excp_is_int,
    input  logic [PC_W-1:0]      pc_i_mtvec,
    input  logic                 pc_i_bjp_req,
    input  logic [PC_W-1:0]      pc_i_bjp_pc,
    input  logic                 pc_i_halt,
    output logic                 pc_o_req_valid,
    output logic [PC_W-1:0]      pc_o_req_pc,
    input  logic                 pc_i_req_ready,
    input  logic                 pc_i_rsp_valid,
    input  logic                 pc_i_rsp_rv32,
    output logic                 pc_o_rsp_live,
    output logic [PC_W-1:0]      pc_o_rsp_pc,
    output logic [PC_W-1:0]      pc_o_pcr,
    output logic [PC_W-1:0]      pc_o_epc
);

    typedef enum logic [0:0] {
        S_ISSUE = 1'b0,
        S_WAIT  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_nxt_q, pc_nxt_d;
    logic [PC_W-1:0]    live_pc_q, live_pc_d;
    logic [CNT_W-1:0]   kill_cnt_q, kill_cnt_d;
    logic [PC_W-1:0]    pcr_q, pcr_d;
    logic               last_len4_q, last_len4_d;

    logic               w_flush;
    logic [PC_W-1:0]    w_target;
    logic [PC_W-1:0]    w_len;
    logic               w_rsp_head;
    logic               w_rsp_live;
    logic               w_rsp_kill;
    logic               w_kill_inc;

    always_comb begin
        w_flush        = pc_i_excp_req | pc_i_bjp_req;
        w_target       = (pc_i_excp_req ? pc_i_mtvec : pc_i_bjp_pc) & ~PC_W'(1);
        w_len          = pc_i_rsp_rv32 ? PC_W'(4) : PC_W'(2);
        pc_o_req_valid = (state_q == S_ISSUE) & ~w_flush & ~pc_i_halt
                       & (kill_cnt_q < CNT_W'(OUTS));
        // Response retires the live fetch; it is only forwarded if not flushed.
        w_rsp_head     = pc_i_rsp_valid & (state_q == S_WAIT) & (kill_cnt_q == '0);
        w_rsp_live     = w_rsp_head & ~w_flush;
        w_rsp_kill     = pc_i_rsp_valid & (kill_cnt_q != '0);
        w_kill_inc     = w_flush & (state_q == S_WAIT) & ~w_rsp_head;

        state_d     = state_q;
        pc_nxt_d    = pc_nxt_q;
        live_pc_d   = live_pc_q;
        kill_cnt_d  = kill_cnt_q;
        pcr_d       = pcr_q;
        last_len4_d = last_len4_q;

        if (pc_o_req_valid && pc_i_req_ready) begin
            live_pc_d = pc_nxt_q;
            state_d   = S_WAIT;
        end
        if (w_rsp_live) begin
            pcr_d       = live_pc_q;
            last_len4_d = pc_i_rsp_rv32;
            pc_nxt_d    = live_pc_q + w_len;
            state_d     = S_ISSUE;
        end
        if (w_flush) begin
            pc_nxt_d = w_target;
            state_d  = S_ISSUE;
        end
        case ({w_kill_inc, w_rsp_kill})
            2'b10:   kill_cnt_d = kill_cnt_q + CNT_W'(1);
            2'b01:   kill_cnt_d = kill_cnt_q - CNT_W'(1);
            default: kill_cnt_d = kill_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_ISSUE;
            pc_nxt_q    <= RST_VEC;
            live_pc_q   <= '0;
            kill_cnt_q  <= '0;
            pcr_q       <= RST_VEC;
            last_len4_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            pc_nxt_q    <= pc_nxt_d;
            live_pc_q   <= live_pc_d;
            kill_cnt_q  <= kill_cnt_d;
            pcr_q       <= pcr_d;
            last_len4_q <= last_len4_d;
        end
    end

    assign pc_o_req_pc   = pc_nxt_q;
    assign pc_o_rsp_live = w_rsp_live;
    assign pc_o_rsp_pc   = live_pc_q;
    assign pc_o_pcr      = pcr_q;
    // Interrupts return to the instruction after the last retired one.
    assign pc_o_epc      = pc_i_excp_is_int
                         ? pcr_q + (last_len4_q ? PC_W'(4) : PC_W'(2))
                         : pcr_q;

endmodule
`default_nettype wire

// File: tb/tb_ifu_pc_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_pc_seq
// Description : Self-checking bench for ifu_pc_seq using an outstanding-fetch
//               queue model, directed scenarios and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_pc_seq;

    localparam int          PC_W = 32;
    localparam logic [31:0] RST  = 32'h8000_0000;
    localparam int          OUTS = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_excp, i_excp_int, i_bjp, i_halt, i_ready, i_rsp, i_rv32;
    logic [31:0] i_mtvec, i_bjp_pc;
    logic        o_req_valid, o_rsp_live;
    logic [31:0] o_req_pc, o_rsp_pc, o_pcr, o_epc;

    always #5 clk = ~clk;

    ifu_pc_seq #(.PC_W(PC_W), .RST_VEC(RST), .OUTS(OUTS)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pc_i_excp_req    (i_excp),
        .pc_i_excp_is_int (i_excp_int),
        .pc_i_mtvec       (i_mtvec),
        .pc_i_bjp_req     (i_bjp),
        .pc_i_bjp_pc      (i_bjp_pc),
        .pc_i_halt        (i_halt),
        .pc_o_req_valid   (o_req_valid),
        .pc_o_req_pc      (o_req_pc),
        .pc_i_req_ready   (i_ready),
        .pc_i_rsp_valid   (i_rsp),
        .pc_i_rsp_rv32    (i_rv32),
        .pc_o_rsp_live    (o_rsp_live),
        .pc_o_rsp_pc      (o_rsp_pc),
        .pc_o_pcr         (o_pcr),
        .pc_o_epc         (o_epc)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: ordered list of fetches the memory still owes, each live or killed.
    typedef struct packed {
        logic [31:0] pc;
        logic        live;
    } ent_t;
    ent_t        q[$];
    logic [31:0] m_pc_next, m_pcr, m_len;
    logic        e_req_valid, e_rsp_live;
    logic [31:0] e_rsp_pc, e_epc;

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc_next = RST;
        m_pcr     = RST;
        m_len     = 32'd4;
    endtask

    task automatic eval();
        bit live_out;
        bit flush;
        #1;
        live_out = 1'b0;
        foreach (q[k]) if (q[k].live) live_out = 1'b1;
        flush       = i_excp | i_bjp;
        e_req_valid = !live_out && !flush && !i_halt && (q.size() < OUTS);
        e_rsp_live  = i_rsp && (q.size() > 0) && q[0].live && !flush;
        e_rsp_pc    = (q.size() > 0) ? q[0].pc : 32'h0;
        e_epc       = i_excp_int ? m_pcr + m_len : m_pcr;
        lit("req_valid", {31'b0, o_req_valid}, {31'b0, e_req_valid});
        lit("req_pc", o_req_pc, m_pc_next);
        lit("rsp_live", {31'b0, o_rsp_live}, {31'b0, e_rsp_live});
        if (e_rsp_live) lit("rsp_pc", o_rsp_pc, e_rsp_pc);
        lit("pcr", o_pcr, m_pcr);
        lit("epc", o_epc, e_epc);
    endtask

    task automatic tick();
        bit          hs;
        logic [31:0] old_pc;
        ent_t        f;
        hs     = e_req_valid && i_ready;
        old_pc = m_pc_next;
        @(posedge clk);
        if (i_rsp && q.size() > 0) begin
            f = q.pop_front();
            if (e_rsp_live) begin
                m_pcr     = f.pc;
                m_len     = i_rv32 ? 32'd4 : 32'd2;
                m_pc_next = f.pc + m_len;
            end
        end
        if (i_excp || i_bjp) begin
            foreach (q[k]) q[k].live = 1'b0;
            m_pc_next = (i_excp ? i_mtvec : i_bjp_pc) & ~32'd1;
        end
        if (hs) begin
            f.pc   = old_pc;
            f.live = 1'b1;
            q.push_back(f);
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit ex, input bit exi, input logic [31:0] mt,
                         input bit bj, input logic [31:0] bp, input bit h,
                         input bit rdy, input bit rv, input bit r32);
        i_excp = ex; i_excp_int = exi; i_mtvec = mt; i_bjp = bj; i_bjp_pc = bp;
        i_halt = h; i_ready = rdy; i_rsp = rv; i_rv32 = r32;
        eval();
    endtask

    task automatic nop(input bit rdy);
        drive(0, 0, 32'h0, 0, 32'h0, 0, rdy, 0, 0);
    endtask

    task automatic rsp(input bit r32);
        drive(0, 0, 32'h0, 0, 32'h0, 0, 1, 1, r32);
    endtask

    task automatic jump(input logic [31:0] t);
        drive(0, 0, 32'h0, 1, t, 0, 1, 0, 0);
    endtask

    initial begin
        i_excp = 0; i_excp_int = 0; i_mtvec = 0; i_bjp = 0; i_bjp_pc = 0;
        i_halt = 0; i_ready = 1; i_rsp = 1; i_rv32 = 0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        lit("rst_req_valid", {31'b0, o_req_valid}, 32'd1);
        lit("rst_req_pc", o_req_pc, RST);
        lit("rst_rsp_live", {31'b0, o_rsp_live}, 32'd0);
        lit("rst_pcr", o_pcr, RST);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch after reset
        nop(1);  lit("a_req0", o_req_pc, 32'h8000_0000); tick();
        rsp(1);  lit("a_live0", {31'b0, o_rsp_live}, 32'd1);
                 lit("a_rsppc0", o_rsp_pc, 32'h8000_0000); tick();
        nop(1);  lit("a_req1", o_req_pc, 32'h8000_0004); lit("a_pcr0", o_pcr, 32'h8000_0000); tick();
        rsp(0);  tick();
        nop(1);  lit("a_req2", o_req_pc, 32'h8000_0006); lit("a_pcr1", o_pcr, 32'h8000_0004); tick();
        rsp(1);  tick();
        nop(0);  lit("a_req3", o_req_pc, 32'h8000_000A); lit("a_pcr2", o_pcr, 32'h8000_0006); tick();

        // Flush in WAIT kills the outstanding fetch
        jump(32'h100); tick();
        nop(1);  lit("b_req100", o_req_pc, 32'h100); tick();
        jump(32'h200); lit("b_flush_gate", {31'b0, o_req_valid}, 32'd0); tick();
        nop(1);  lit("b_req200_v", {31'b0, o_req_valid}, 32'd1);
                 lit("b_req200", o_req_pc, 32'h200); tick();
        rsp(1);  lit("b_drop", {31'b0, o_rsp_live}, 32'd0); tick();
        rsp(1);  lit("b_live", {31'b0, o_rsp_live}, 32'd1); lit("b_rsppc", o_rsp_pc, 32'h200); tick();

        // Two kills saturate OUTS=2
        nop(1);  tick();
        jump(32'h300); tick();
        nop(1);  lit("c_req300", o_req_pc, 32'h300); tick();
        jump(32'h400); tick();
        nop(1);  lit("c_sat0", {31'b0, o_req_valid}, 32'd0); tick();
        nop(1);  lit("c_sat1", {31'b0, o_req_valid}, 32'd0); tick();
        rsp(1);  lit("c_sat2", {31'b0, o_req_valid}, 32'd0); tick();
        nop(1);  lit("c_rel_v", {31'b0, o_req_valid}, 32'd1); lit("c_rel", o_req_pc, 32'h400); tick();
        rsp(1);  lit("c_drop", {31'b0, o_rsp_live}, 32'd0); tick();
        rsp(0);  lit("c_live", {31'b0, o_rsp_live}, 32'd1); tick();

        // Trap beats branch; flush coincident with live response
        nop(0);  lit("d_req402", o_req_pc, 32'h402); tick();
        drive(1, 0, 32'h41, 1, 32'h300, 0, 1, 0, 0); tick();
        nop(1);  lit("d_trap", o_req_pc, 32'h40); tick();
        drive(0, 0, 32'h0, 1, 32'h500, 0, 1, 1, 0);
                 lit("d_coinc_drop", {31'b0, o_rsp_live}, 32'd0); tick();
        nop(1);  lit("d_pcr_keep", o_pcr, 32'h400); lit("d_req500", o_req_pc, 32'h500); tick();
        rsp(1);  lit("d_nokill", {31'b0, o_rsp_live}, 32'd1); tick();

        // EPC
        jump(32'h1000); tick();
        nop(1);  tick();
        rsp(0);  tick();
        drive(0, 1, 32'h0, 0, 32'h0, 0, 0, 0, 0); lit("e_epc_int", o_epc, 32'h1002); tick();
        drive(0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0); lit("e_epc_exc", o_epc, 32'h1000); tick();

        // Wrap-around and halt
        jump(32'hFFFF_FFFE); tick();
        nop(1);  lit("f_reqtop", o_req_pc, 32'hFFFF_FFFE); tick();
        rsp(0);  tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 32'h0, 0, 32'h0, 1, 1, 0, 0);
            lit("f_halt", {31'b0, o_req_valid}, 32'd0);
            tick();
        end
        nop(1);  lit("f_rel_v", {31'b0, o_req_valid}, 32'd1); lit("f_wrap", o_req_pc, 32'h0); tick();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            bit r;
            r = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            drive($urandom_range(0, 99) < 3, $urandom_range(0, 1) == 1, $urandom,
                  $urandom_range(0, 99) < 8, $urandom,
                  $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 70,
                  r, $urandom_range(0, 1) == 1);
            tick();
        end

        // Asynchronous reset mid-operation
        i_excp = 0; i_excp_int = 0; i_bjp = 0; i_halt = 0; i_rsp = 0; i_ready = 0;
        rst_n = 1'b0;
        #1;
        lit("h_rst_v", {31'b0, o_req_valid}, 32'd1);
        lit("h_rst_pc", o_req_pc, RST);
        lit("h_rst_pcr", o_pcr, RST);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nop(1);  lit("h_req", o_req_pc, RST); tick();
        rsp(0);  lit("h_live", {31'b0, o_rsp_live}, 32'd1); tick();
        nop(0);  lit("h_next", o_req_pc, RST + 32'd2); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
